regfile_scoreboard: RTL and testbench

- 32x32 integer register file with a per-register pending-write scoreboard.
- Sinks the writeback stage's write port (wb_rd / wb_write_data / wb_wr_enable) and serves the decode stage's operand reads.
- Decode marks rd pending on issue; writeback retires the mark; killed in-flight instructions cancel it.
- Drives the decode stall for RAW hazards and pending-counter saturation.

---
 rtl/regfile_scoreboard_if.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 95 +++++++++
 tb/tb_regfile_scoreboard.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Pipeline-side bundle for the register file: writeback port, decode read/issue
// port, flush kills and the scoreboard status outputs.
interface regfile_scoreboard_if #(
    parameter int XLEN = 32
);
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_write_data;
    logic            wb_wr_enable;

    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [4:0]      id_rd;
    logic            id_rd_we;
    logic            id_issue;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic            id_stall;

    logic            kill0_valid;
    logic [4:0]      kill0_rd;
    logic            kill1_valid;
    logic [4:0]      kill1_rd;

    logic            sb_error;

    // Pipeline side drives requests and consumes operands/stall.
    modport master (
        output wb_rd, wb_write_data, wb_wr_enable,
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_issue,
        output kill0_valid, kill0_rd, kill1_valid, kill1_rd,
        input  id_rs1_data, id_rs2_data, id_stall, sb_error
    );

    modport slave (
        input  wb_rd, wb_write_data, wb_wr_enable,
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_issue,
        input  kill0_valid, kill0_rd, kill1_valid, kill1_rd,
        output id_rs1_data, id_rs2_data, id_stall, sb_error
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32xXLEN integer register file with write-through bypass and a per-register
// pending-write counter that stalls decode on RAW hazards and counter saturation.
module regfile_scoreboard #(
    parameter int PEND_W = 2,
    parameter int XLEN   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_scoreboard_if.slave bus
);
    localparam int DW = PEND_W + 2;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]   r_regs [32];
    logic [PEND_W-1:0] r_cnt  [32];
    logic              r_sb_error;

    logic [1:0]        w_dec      [32];
    logic [PEND_W-1:0] w_eff      [32];
    logic [PEND_W-1:0] w_cnt_next [32];
    logic [31:0]       w_under;
    logic              w_rs1_haz;
    logic              w_rs2_haz;
    logic              w_sat;
    logic              w_stall;
    logic              w_inc_ok;

    // Per-register decrement, floored effective count and next counter value.
    for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
        if (gi == 0) begin : g_x0
            assign w_dec[gi]      = 2'd0;
            assign w_eff[gi]      = '0;
            assign w_cnt_next[gi] = '0;
            assign w_under[gi]    = 1'b0;
        end else begin : g_xn
            logic [DW-1:0] w_cnt_ext;
            logic [DW-1:0] w_dec_ext;
            logic [DW-1:0] w_sum;
            logic          w_inc;

            assign w_dec[gi] = {1'b0, bus.wb_wr_enable && (bus.wb_rd == 5'(gi))}
                             + {1'b0, bus.kill0_valid  && (bus.kill0_rd == 5'(gi))}
                             + {1'b0, bus.kill1_valid  && (bus.kill1_rd == 5'(gi))};
            assign w_cnt_ext = DW'(r_cnt[gi]);
            assign w_dec_ext = DW'(w_dec[gi]);
            assign w_eff[gi] = (w_dec_ext >= w_cnt_ext) ? '0
                             : PEND_W'(w_cnt_ext - w_dec_ext);
            assign w_inc     = w_inc_ok && (bus.id_rd == 5'(gi));
            assign w_sum     = w_cnt_ext + DW'(w_inc);
            assign w_under[gi]    = (w_dec_ext > w_sum);
            // Cannot exceed CNT_MAX: an increment into a full counter is stalled.
            assign w_cnt_next[gi] = w_under[gi] ? '0 : PEND_W'(w_sum - w_dec_ext);
        end
    end

    assign w_rs1_haz = bus.id_rs1_used && (bus.id_rs1 != 5'd0) && (w_eff[bus.id_rs1] != '0);
    assign w_rs2_haz = bus.id_rs2_used && (bus.id_rs2 != 5'd0) && (w_eff[bus.id_rs2] != '0);
    assign w_sat     = bus.id_rd_we && (bus.id_rd != 5'd0) && (w_eff[bus.id_rd] == CNT_MAX);
    assign w_stall   = bus.id_issue && (w_rs1_haz || w_rs2_haz || w_sat);
    assign w_inc_ok  = bus.id_issue && !w_stall && bus.id_rd_we && (bus.id_rd != 5'd0);

    assign bus.id_stall = w_stall;
    assign bus.sb_error = r_sb_error;

    assign bus.id_rs1_data = (bus.id_rs1 == 5'd0) ? '0
                           : (bus.wb_wr_enable && bus.wb_rd == bus.id_rs1) ? bus.wb_write_data
                           : r_regs[bus.id_rs1];
    assign bus.id_rs2_data = (bus.id_rs2 == 5'd0) ? '0
                           : (bus.wb_wr_enable && bus.wb_rd == bus.id_rs2) ? bus.wb_write_data
                           : r_regs[bus.id_rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.wb_wr_enable && (bus.wb_rd != 5'd0)) begin
            r_regs[bus.wb_rd] <= bus.wb_write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
            r_sb_error <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_sb_error <= r_sb_error | (|w_under);
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, RAW stall, saturation, x0 and
// underflow/reset behaviour, with hand-computed expectations.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard_if #(.XLEN(32)) bus ();

    regfile_scoreboard #(.PEND_W(2), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic idle();
        bus.wb_rd = 5'd0; bus.wb_write_data = '0; bus.wb_wr_enable = 1'b0;
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
        bus.id_rd = 5'd0; bus.id_rd_we = 1'b0; bus.id_issue = 1'b0;
        bus.kill0_valid = 1'b0; bus.kill0_rd = 5'd0; bus.kill1_valid = 1'b0; bus.kill1_rd = 5'd0;
    endtask

    // Commit on the next rising edge, then return 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        bus.id_issue = 1'b1; bus.id_rd_we = 1'b1; bus.id_rd = rd;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1; bus.id_issue = 1'b1;
        #1;
        check("reset_rs1_x5", bus.id_rs1_data, 32'h0);
        check("reset_rs2_x0", bus.id_rs2_data, 32'h0);
        check("reset_stall", {31'b0, bus.id_stall}, 32'h0);
        check("reset_sb_error", {31'b0, bus.sb_error}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // x3: issue first so the later writeback retires a real pending mark.
        issue_rd(5'd3);
        tick();
        bus.wb_wr_enable = 1'b1; bus.wb_rd = 5'd3; bus.wb_write_data = 32'hDEADBEEF;
        bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1; bus.id_issue = 1'b1;
        #1;
        check("bypass_x3", bus.id_rs1_data, 32'hDEADBEEF);
        check("bypass_x3_nostall", {31'b0, bus.id_stall}, 32'h0);
        tick();
        bus.id_rs1 = 5'd3;
        #1;
        check("array_x3", bus.id_rs1_data, 32'hDEADBEEF);

        // RAW on x7.
        tick();
        issue_rd(5'd7);
        #1;
        check("issue_x7_stall", {31'b0, bus.id_stall}, 32'h0);
        tick();
        bus.id_issue = 1'b1; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
        #1;
        check("raw_x7_stall", {31'b0, bus.id_stall}, 32'h1);
        bus.wb_wr_enable = 1'b1; bus.wb_rd = 5'd7; bus.wb_write_data = 32'h12;
        #1;
        check("raw_x7_wb_stall", {31'b0, bus.id_stall}, 32'h0);
        check("raw_x7_wb_data", bus.id_rs2_data, 32'h12);
        tick();
        bus.id_issue = 1'b1; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
        #1;
        check("x7_retired", {31'b0, bus.id_stall}, 32'h0);
        check("x7_array", bus.id_rs2_data, 32'h12);

        // Saturation on x9.
        for (int k = 0; k < 3; k++) begin
            tick();
            issue_rd(5'd9);
            #1;
            check($sformatf("x9_issue%0d", k), {31'b0, bus.id_stall}, 32'h0);
        end
        tick();
        issue_rd(5'd9);
        #1;
        check("x9_saturated", {31'b0, bus.id_stall}, 32'h1);
        bus.kill0_valid = 1'b1; bus.kill0_rd = 5'd9;
        #1;
        check("x9_kill_accept", {31'b0, bus.id_stall}, 32'h0);
        tick();
        issue_rd(5'd9);
        #1;
        check("x9_still_full", {31'b0, bus.id_stall}, 32'h1);

        // x0 is hardwired.
        tick();
        bus.wb_wr_enable = 1'b1; bus.wb_rd = 5'd0; bus.wb_write_data = 32'h55;
        issue_rd(5'd0);
        bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
        #1;
        check("x0_bypass", bus.id_rs1_data, 32'h0);
        check("x0_issue_stall", {31'b0, bus.id_stall}, 32'h0);
        tick();
        bus.id_issue = 1'b1; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
        #1;
        check("x0_read", bus.id_rs1_data, 32'h0);
        check("x0_stall", {31'b0, bus.id_stall}, 32'h0);
        check("no_error_yet", {31'b0, bus.sb_error}, 32'h0);

        // Underflow on x4.
        tick();
        bus.kill1_valid = 1'b1; bus.kill1_rd = 5'd4;
        tick();
        check("x4_underflow_err", {31'b0, bus.sb_error}, 32'h1);
        bus.id_issue = 1'b1; bus.id_rs1 = 5'd4; bus.id_rs1_used = 1'b1;
        #1;
        check("x4_count_zero", {31'b0, bus.id_stall}, 32'h0);
        tick();
        tick();
        check("sb_error_sticky", {31'b0, bus.sb_error}, 32'h1);

        // Async reset mid-operation clears everything at once.
        #2;
        rst_n = 1'b0;
        bus.id_issue = 1'b1; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1'b1; bus.id_rs2 = 5'd3;
        #1;
        check("rst_clears_err", {31'b0, bus.sb_error}, 32'h0);
        check("rst_clears_x3", bus.id_rs2_data, 32'h0);
        check("rst_clears_x9cnt", {31'b0, bus.id_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Stale writeback after reset: data lands, counter underflow flags.
        bus.wb_wr_enable = 1'b1; bus.wb_rd = 5'd9; bus.wb_write_data = 32'hA5A5_0009;
        tick();
        bus.id_rs1 = 5'd9;
        #1;
        check("stale_wb_data", bus.id_rs1_data, 32'hA5A5_0009);
        check("stale_wb_err", {31'b0, bus.sb_error}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
